ps2_rx_buffered: RTL and testbench

//  - System-clock-domain PS/2 keyboard receiver: synchronises and deglitches ps2_clk/ps2_dat,

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_sync_filter.sv | 36 +++
 rtl/ps2_rx_buffered.sv | 250 +++++++++++++++++++++++++
 tb/tb_ps2_rx_buffered.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Purpose: shared types and helpers for the PS/2 receiver (FSM states, prefix codes, FIFO entry).
// Latency: n/a (package).
// Backpressure: n/a (package).
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam logic [7:0] PS2_EXT = 8'hE0;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } fifo_entry_t;

    // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Purpose: 2-flop synchroniser plus FILTER_LEN-sample deglitch for one raw PS/2 line.
// Latency: 3 + FILTER_LEN clocks from pin change to filtered output change.
// Backpressure: none; free-running, output idles high after reset.
module ps2_sync_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_line,
    output logic filt_line
);

    logic                  sync_a;
    logic                  sync_b;
    logic [FILTER_LEN-1:0] hist;

    // Synchronise, keep the last FILTER_LEN samples, and only move the output when they all agree.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_a    <= 1'b1;
            sync_b    <= 1'b1;
            hist      <= '1;
            filt_line <= 1'b1;
        end else begin
            sync_a <= raw_line;
            sync_b <= sync_a;
            hist   <= {hist[FILTER_LEN-2:0], sync_b};
            if (&hist) begin
                filt_line <= 1'b1;
            end else if (~|hist) begin
                filt_line <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_buffered.sv
// Purpose: PS/2 keyboard receiver with error checks and a FWFT scan-code FIFO; PS2_PREFIX_DECODE_EN folds E0/F0 into flags.
// Latency: code_valid rises 2 clocks after the stop-bit falling edge is detected (filter delay comes before that).
// Backpressure: code_valid/code_ready pop; a good byte arriving with the FIFO full and no pop is dropped with an overflow pulse.
module ps2_rx_buffered
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             ps2_clk,
    input  logic                             ps2_dat,
    output logic [7:0]                       code_data,
    output logic                             code_brk,
    output logic                             code_ext,
    output logic                             code_valid,
    input  logic                             code_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic                             parity_err,
    output logic                             frame_err,
    output logic                             overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

`ifdef PS2_PREFIX_DECODE_EN
    typedef fifo_entry_t fifo_word_t;
`else
    typedef logic [7:0] fifo_word_t;
`endif

    logic       clk_filt;
    logic       dat_filt;
    logic       clk_filt_prev;
    logic       fall_en;

    ps2_state_t state;
    ps2_state_t state_next;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       par_bit;
    logic [TW-1:0] to_cnt;

    logic       timeout_hit;
    logic       stop_eval;
    logic       par_bad;
    logic       stop_bad;
    logic       good_byte;
    logic       is_prefix;

    logic       push_q;
    fifo_word_t push_word_q;
    fifo_word_t push_word;
    fifo_word_t mem [FIFO_DEPTH];
    fifo_word_t head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic       full;
    logic       pop;
    logic       wr_en;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clock     (clock),
        .reset     (reset),
        .raw_line  (ps2_clk),
        .filt_line (clk_filt)
    );

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clock     (clock),
        .reset     (reset),
        .raw_line  (ps2_dat),
        .filt_line (dat_filt)
    );

    assign fall_en = clk_filt_prev & ~clk_filt;

    // Remember the previous filtered clock so a 1->0 transition yields a single-cycle strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_filt_prev <= 1'b1;
        end else begin
            clk_filt_prev <= clk_filt;
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus stop-bit evaluation; a timeout overrides any edge in the same cycle.
    always_comb begin
        state_next  = state;
        timeout_hit = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
        stop_eval   = 1'b0;
        par_bad     = !odd_parity_ok(shift_reg, par_bit);
        stop_bad    = !dat_filt;
        if (timeout_hit) begin
            state_next = IDLE;
        end else if (fall_en) begin
            case (state)
                IDLE:    if (!dat_filt) state_next = DATA;
                DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
                PARITY:  state_next = STOP;
                STOP: begin
                    state_next = IDLE;
                    stop_eval  = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
        good_byte = stop_eval && !par_bad && !stop_bad;
    end

    // Shift data in LSB-first and capture the parity bit, all on filtered clock falls.
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt   <= 3'd0;
            shift_reg <= 8'd0;
            par_bit   <= 1'b0;
        end else if (fall_en) begin
            case (state)
                IDLE:   bit_cnt <= 3'd0;
                DATA: begin
                    shift_reg <= {dat_filt, shift_reg[7:1]};
                    bit_cnt   <= bit_cnt + 3'd1;
                end
                PARITY: par_bit <= dat_filt;
                default: ;
            endcase
        end
    end

    // Mid-frame watchdog: runs only while a frame is open, restarts on each clock fall.
    always_ff @(posedge clock) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (fall_en || state == IDLE || timeout_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    // Error pulses; parity failure masks a bad stop bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            parity_err <= stop_eval && par_bad;
            frame_err  <= timeout_hit || (stop_eval && !par_bad && stop_bad);
        end
    end

`ifdef PS2_PREFIX_DECODE_EN
    logic brk_pend;
    logic ext_pend;

    assign is_prefix = (shift_reg == PS2_EXT) || (shift_reg == PS2_BRK);
    assign push_word = '{brk: brk_pend, ext: ext_pend, code: shift_reg};
    assign head      = mem[rd_ptr];
    assign code_data = code_valid ? head.code : 8'd0;
    assign code_brk  = code_valid ? head.brk  : 1'b0;
    assign code_ext  = code_valid ? head.ext  : 1'b0;

    // Prefix bytes arm flags; the next real code consumes them; any error forgets them.
    always_ff @(posedge clock) begin
        if (reset) begin
            brk_pend <= 1'b0;
            ext_pend <= 1'b0;
        end else if (timeout_hit || (stop_eval && (par_bad || stop_bad))) begin
            brk_pend <= 1'b0;
            ext_pend <= 1'b0;
        end else if (good_byte) begin
            if (shift_reg == PS2_EXT) begin
                ext_pend <= 1'b1;
            end else if (shift_reg == PS2_BRK) begin
                brk_pend <= 1'b1;
            end else begin
                brk_pend <= 1'b0;
                ext_pend <= 1'b0;
            end
        end
    end
`else
    assign is_prefix = 1'b0;
    assign push_word = shift_reg;
    assign head      = mem[rd_ptr];
    assign code_data = code_valid ? head : 8'd0;
    assign code_brk  = 1'b0;
    assign code_ext  = 1'b0;
`endif

    // Stage a good byte for the FIFO one cycle after the stop edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            push_q      <= 1'b0;
            push_word_q <= '0;
        end else begin
            push_q      <= good_byte && !is_prefix;
            push_word_q <= push_word;
        end
    end

    assign code_valid = (fifo_count != '0);
    assign full       = (fifo_count == CW'(FIFO_DEPTH));
    assign pop        = code_valid && code_ready;
    assign wr_en      = push_q && (!full || pop);

    // FIFO storage; no reset needed since reads are gated by occupancy.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_word_q;
        end
    end

    // FIFO pointers, occupancy and overflow pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            overflow <= push_q && full && !pop;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_rx_buffered.sv
// Purpose: directed self-checking bench for ps2_rx_buffered (framing, errors, timeout, glitch, FIFO, prefixes, reset).
// Latency: PS/2 bit period is 40 system clocks; checks are taken on falling clock edges.
// Backpressure: code_ready is driven low to fill the FIFO and pulsed to pop.
`timescale 1ns/1ps
module tb_ps2_rx_buffered;

    localparam int FILTER_LEN = 4;
    localparam int TIMEOUT    = 1000;
    localparam int DEPTH      = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] code_data;
    logic       code_brk;
    logic       code_ext;
    logic       code_valid;
    logic       code_ready = 1'b0;
    logic [3:0] fifo_count;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;
    int n_perr = 0;
    int n_ferr = 0;
    int n_ovf = 0;

    ps2_rx_buffered #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .code_data  (code_data),
        .code_brk   (code_brk),
        .code_ext   (code_ext),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .fifo_count (fifo_count),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    // Count high cycles of each error strobe; a clean pulse contributes exactly 1.
    always @(negedge clock) begin
        if (parity_err) n_perr++;
        if (frame_err)  n_ferr++;
        if (overflow)   n_ovf++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // bits[0] start, bits[8:1] data LSB first, bits[9] parity, bits[10] stop.
    function automatic logic [10:0] make_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic par;
        par = (~^d) ^ bad_par;
        return {~bad_stop, par, d, 1'b0};
    endfunction

    // Drive nbits of a frame; optional clk glitch during bit glitch_bit, optional pop timed to the final push.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_bit, input bit pop_at_last);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = bits[i];
            if (i == glitch_bit) begin
                cyc(3);
                ps2_clk = 1'b0;
                cyc(2);
                ps2_clk = 1'b1;
                cyc(5);
            end else begin
                cyc(10);
            end
            ps2_clk = 1'b0;
            if (pop_at_last && i == nbits - 1) begin
                cyc(8);
                code_ready = 1'b1;
                cyc(1);
                code_ready = 1'b0;
                cyc(11);
            end else begin
                cyc(20);
            end
            ps2_clk = 1'b1;
            cyc(10);
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_bits(make_frame(d, 1'b0, 1'b0), 11, -1, 1'b0);
        cyc(5);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, code_valid, 1);
        check({tag, "_data"}, code_data, exp);
        code_ready = 1'b1;
        cyc(1);
        code_ready = 1'b0;
    endtask

    initial begin
        int p0;
        int f0;
        int o0;
        int since;

        cyc(5);
        check("rst_valid", code_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_errs", {parity_err, frame_err, overflow, code_brk, code_ext}, 0);
        reset = 1'b0;
        cyc(5);

        // Good frame 0x1C.
        send_byte(8'h1C);
        check("good_count", fifo_count, 1);
        pop_expect("good", 8'h1C);
        check("good_popped", code_valid, 0);
        check("good_no_err", n_perr + n_ferr + n_ovf, 0);

        // Parity bit inverted.
        p0 = n_perr;
        send_bits(make_frame(8'h1C, 1'b1, 1'b0), 11, -1, 1'b0);
        cyc(5);
        check("par_pulse", n_perr - p0, 1);
        check("par_count", fifo_count, 0);

        // Stop bit low.
        f0 = n_ferr;
        send_bits(make_frame(8'h5A, 1'b0, 1'b1), 11, -1, 1'b0);
        cyc(5);
        check("stop_pulse", n_ferr - f0, 1);
        check("stop_count", fifo_count, 0);

        // Five clock edges then silence: timeout.
        f0 = n_ferr;
        since = -1;
        send_bits(make_frame(8'h2A, 1'b0, 1'b0), 5, -1, 1'b0);
        for (int k = 0; k < TIMEOUT + 200; k++) begin
            @(negedge clock);
            if (frame_err && since < 0) since = k + 31;
        end
        check("tmo_window", (since >= TIMEOUT) && (since <= TIMEOUT + 16), 1);
        check("tmo_pulse", n_ferr - f0, 1);
        send_byte(8'h2A);
        pop_expect("tmo_next", 8'h2A);

        // Short glitch on ps2_clk mid-frame.
        p0 = n_perr;
        f0 = n_ferr;
        send_bits(make_frame(8'h55, 1'b0, 1'b0), 11, 4, 1'b0);
        cyc(5);
        check("glitch_count", fifo_count, 1);
        check("glitch_errs", (n_perr - p0) + (n_ferr - f0), 0);
        pop_expect("glitch", 8'h55);

        // Fill FIFO, then one more: overflow.
        o0 = n_ovf;
        for (int b = 1; b <= DEPTH + 1; b++) send_byte(8'(b));
        check("ovf_pulse", n_ovf - o0, 1);
        check("ovf_count", fifo_count, DEPTH);

        // Full FIFO, push coincides with a pop.
        o0 = n_ovf;
        send_bits(make_frame(8'h0A, 1'b0, 1'b0), 11, -1, 1'b1);
        cyc(5);
        check("fullpop_ovf", n_ovf - o0, 0);
        check("fullpop_count", fifo_count, DEPTH);
        for (int b = 2; b <= DEPTH; b++) pop_expect("drain", 8'(b));
        pop_expect("drain_last", 8'h0A);
        check("drain_empty", code_valid, 0);

        // Prefix sequence E0 F0 74.
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h74);
`ifdef PS2_PREFIX_DECODE_EN
        check("pfx_count", fifo_count, 1);
        check("pfx_flags", {code_brk, code_ext}, 2'b11);
        pop_expect("pfx", 8'h74);
`else
        check("raw_count", fifo_count, 3);
        check("raw_flags", {code_brk, code_ext}, 2'b00);
        pop_expect("raw0", 8'hE0);
        pop_expect("raw1", 8'hF0);
        pop_expect("raw2", 8'h74);
`endif
        check("pfx_empty", code_valid, 0);

        // Reset mid-frame with three entries queued.
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        check("pre_rst_count", fifo_count, 3);
        send_bits(make_frame(8'h44, 1'b0, 1'b0), 3, -1, 1'b0);
        reset = 1'b1;
        cyc(1);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_outs", {code_valid, code_data, code_brk, code_ext, parity_err, frame_err, overflow}, 0);
        reset = 1'b0;
        cyc(10);
        send_byte(8'h44);
        check("post_rst_count", fifo_count, 1);
        pop_expect("post_rst", 8'h44);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
